// File: rtl/handshake_decoder.sv
// Index-to-one-hot decoder behind a valid/ready stream with a 2-entry elastic buffer.
// Decode happens at acceptance; all outputs, including in_ready, are registered.
module handshake_decoder #(
  parameter int NUM_OUTPUTS = 8,
  localparam int INDEX_WIDTH = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INDEX_WIDTH-1:0] index,
  input  logic                   index_valid,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_OUTPUTS-1:0] out_data,
  output logic                   out_range_err
);

  localparam int ENTRY_WIDTH = NUM_OUTPUTS + 1;

  // Entry layout is {err, one_hot}.
  function automatic logic [ENTRY_WIDTH-1:0] decode_entry(
    input logic                   idx_vld,
    input logic [INDEX_WIDTH-1:0] idx
  );
    logic [NUM_OUTPUTS-1:0] one_hot;
    logic                   err;
    one_hot = '0;
    err     = 1'b0;
    if (idx_vld) begin
      if (32'(idx) < NUM_OUTPUTS) begin
        one_hot[idx] = 1'b1;
      end else begin
        err = 1'b1;
      end
    end else begin
      err = 1'b0;
    end
    return {err, one_hot};
  endfunction

  logic [ENTRY_WIDTH-1:0] mem_r [2];
  logic                   head_r;
  logic                   tail_r;
  logic [1:0]             count_r;

  logic                   push_s;
  logic                   pop_s;
  logic                   head_nxt_s;
  logic                   tail_nxt_s;
  logic [1:0]             count_nxt_s;
  logic [ENTRY_WIDTH-1:0] word_s;
  logic [ENTRY_WIDTH-1:0] head_word_s;

  // Next-state pointers/count and the entry that will sit at the head after this edge.
  always_comb begin
    push_s      = in_valid & in_ready;
    pop_s       = out_valid & out_ready;
    word_s      = decode_entry(index_valid, index);
    head_nxt_s  = pop_s ? ~head_r : head_r;
    tail_nxt_s  = push_s ? ~tail_r : tail_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + 2'd1;
      2'b01:   count_nxt_s = count_r - 2'd1;
      default: count_nxt_s = count_r;
    endcase
    // The word being written lands at the head only when it fills the next head slot.
    if (push_s && (tail_r == head_nxt_s)) begin
      head_word_s = word_s;
    end else begin
      head_word_s = mem_r[head_nxt_s];
    end
  end

  // Storage array; stale contents are never exposed, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_r[tail_r] <= word_s;
    end
  end

  // Pointer/count state and registered stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r        <= 1'b0;
      tail_r        <= 1'b0;
      count_r       <= 2'd0;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_range_err <= 1'b0;
    end else begin
      head_r    <= head_nxt_s;
      tail_r    <= tail_nxt_s;
      count_r   <= count_nxt_s;
      in_ready  <= (count_nxt_s != 2'd2);
      out_valid <= (count_nxt_s != 2'd0);
      if (count_nxt_s != 2'd0) begin
        out_data      <= head_word_s[NUM_OUTPUTS-1:0];
        out_range_err <= head_word_s[NUM_OUTPUTS];
      end else begin
        out_data      <= '0;
        out_range_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_handshake_decoder.sv
// Drives NUM_OUTPUTS=8 and NUM_OUTPUTS=5 instances with shared stimulus and checks both
// against queue-based reference models every cycle, plus directed literal expectations.
module tb_handshake_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [2:0] index = 3'd0;
  logic       index_valid = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready8, out_valid8, err8;
  logic [7:0] out_data8;
  logic       in_ready5, out_valid5, err5;
  logic [4:0] out_data5;

  int n_cmp  = 0;
  int n_fail = 0;
  bit started = 1'b0;

  logic [8:0] q8[$];
  logic [8:0] q5[$];

  always #5 clk = ~clk;

  handshake_decoder #(.NUM_OUTPUTS(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .index(index), .index_valid(index_valid), .out_valid(out_valid8),
    .out_ready(out_ready), .out_data(out_data8), .out_range_err(err8)
  );

  handshake_decoder #(.NUM_OUTPUTS(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready5),
    .index(index), .index_valid(index_valid), .out_valid(out_valid5),
    .out_ready(out_ready), .out_data(out_data5), .out_range_err(err5)
  );

  // Expected entry {err, data} for a decoder of width n.
  function automatic logic [8:0] expect_word(input logic iv, input logic [2:0] idx, input int n);
    logic [7:0] one;
    one = 8'd1;
    if (!iv) return 9'd0;
    if (int'(idx) < n) return {1'b0, one << idx};
    return 9'h100;
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a bounded queue of decoded words per instance.
  always @(posedge clk) begin : model
    int s8, s5;
    started = 1'b1;
    if (rst) begin
      q8.delete();
      q5.delete();
    end else begin
      s8 = q8.size();
      s5 = q5.size();
      if (in_valid && s8 < 2) q8.push_back(expect_word(index_valid, index, 8));
      if (out_ready && s8 > 0) void'(q8.pop_front());
      if (in_valid && s5 < 2) q5.push_back(expect_word(index_valid, index, 5));
      if (out_ready && s5 > 0) void'(q5.pop_front());
    end
  end

  always @(negedge clk) begin : compare
    logic [8:0] e8, e5;
    if (started) begin
      e8 = (q8.size() > 0) ? q8[0] : 9'd0;
      e5 = (q5.size() > 0) ? q5[0] : 9'd0;
      check("in_ready8",  {8'd0, in_ready8},  {8'd0, q8.size() < 2});
      check("out_valid8", {8'd0, out_valid8}, {8'd0, q8.size() > 0});
      check("word8",      {err8, out_data8},  e8);
      check("in_ready5",  {8'd0, in_ready5},  {8'd0, q5.size() < 2});
      check("out_valid5", {8'd0, out_valid5}, {8'd0, q5.size() > 0});
      check("word5",      {err5, 3'd0, out_data5}, e5);
    end
  end

  task automatic drive(input logic iv, input logic [2:0] idx, input logic ivld,
                       input logic ordy, input logic r = 1'b0);
    @(negedge clk);
    #1;
    rst         = r;
    in_valid    = iv;
    index       = idx;
    index_valid = ivld;
    out_ready   = ordy;
  endtask

  task automatic after_edge;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    after_edge();
    check("rst_valid", {8'd0, out_valid8}, 9'd0);
    check("rst_data",  {err8, out_data8},  9'd0);
    check("rst_ready", {8'd0, in_ready8},  9'd1);

    // Single words
    drive(1'b1, 3'd5, 1'b1, 1'b1); after_edge();
    check("idx5_valid", {8'd0, out_valid8}, 9'd1);
    check("idx5_data",  {err8, out_data8},  9'h020);
    drive(1'b1, 3'd0, 1'b1, 1'b1); after_edge();
    check("idx0_data",  {err8, out_data8},  9'h001);
    drive(1'b1, 3'd3, 1'b0, 1'b1); after_edge();
    check("none_valid", {8'd0, out_valid8}, 9'd1);
    check("none_data",  {err8, out_data8},  9'h000);

    // Sweep
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 1'b1, 1'b1); after_edge();
      check("sweep_data",  {err8, out_data8}, {1'b0, 8'(1 << i)});
      check("sweep_ready", {8'd0, in_ready8}, 9'd1);
    end
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    drive(1'b0, 3'd0, 1'b0, 1'b1);

    // Backpressure
    drive(1'b1, 3'd1, 1'b1, 1'b0);
    drive(1'b1, 3'd2, 1'b1, 1'b0); after_edge();
    check("bp_full_ready", {8'd0, in_ready8}, 9'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'd3, 1'b1, 1'b0); after_edge();
      check("bp_hold", {err8, out_data8}, 9'h002);
    end
    drive(1'b1, 3'd3, 1'b1, 1'b1); after_edge();
    check("bp_second", {err8, out_data8}, 9'h004);
    drive(1'b1, 3'd3, 1'b1, 1'b1); after_edge();
    check("bp_third", {err8, out_data8}, 9'h008);
    drive(1'b0, 3'd0, 1'b0, 1'b1); after_edge();
    check("bp_drained", {8'd0, out_valid8}, 9'd0);

    // Simultaneous push/pop at one entry
    drive(1'b1, 3'd6, 1'b1, 1'b0);
    drive(1'b1, 3'd7, 1'b1, 1'b1); after_edge();
    check("pp_data",  {err8, out_data8},  9'h080);
    check("pp_ready", {8'd0, in_ready8},  9'd1);
    drive(1'b0, 3'd0, 1'b0, 1'b1);

    // Out-of-range on the 5-wide instance
    drive(1'b1, 3'd6, 1'b1, 1'b1); after_edge();
    check("oor5_word", {err5, 3'd0, out_data5}, 9'h100);
    drive(1'b1, 3'd4, 1'b1, 1'b1); after_edge();
    check("idx4_5_word", {err5, 3'd0, out_data5}, 9'h010);
    drive(1'b0, 3'd0, 1'b0, 1'b1);

    // Reset mid-stream
    drive(1'b1, 3'd1, 1'b1, 1'b0);
    drive(1'b1, 3'd2, 1'b1, 1'b0);
    drive(1'b1, 3'd3, 1'b1, 1'b0, 1'b1); after_edge();
    check("mid_rst_valid", {8'd0, out_valid8}, 9'd0);
    check("mid_rst_data",  {err8, out_data8},  9'd0);
    check("mid_rst_ready", {8'd0, in_ready8},  9'd1);
    drive(1'b1, 3'd2, 1'b1, 1'b1); after_edge();
    check("post_rst_data", {err8, out_data8}, 9'h004);
    drive(1'b0, 3'd0, 1'b0, 1'b1); after_edge();
    check("post_rst_empty", {8'd0, out_valid8}, 9'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 149) == 0));
    end
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
